// File: rtl/dec138_scan_pkg.sv
// rtl/dec138_scan_pkg.sv - shared state type and enable encodings for the 3-to-8 decoder scan sequencer
package dec138_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        BLANK  = 2'd2,
        DONE   = 2'd3
    } scan_state_t;

    // Enable triple ordered {e1_bar, e2_bar, e3}
    localparam logic [2:0] EN_ON  = 3'b001;
    localparam logic [2:0] EN_OFF = 3'b110;

    function automatic logic state_is_busy(scan_state_t s);
        return (s == ACTIVE) || (s == BLANK);
    endfunction

endpackage

// File: rtl/dec138_scan_seq_slot_next_find.sv
// rtl/dec138_scan_seq_slot_next_find.sv - combinational search for the next and the lowest enabled slot
module slot_next_find (
    input  logic [7:0] mask,
    input  logic [2:0] idx,
    output logic [2:0] next_idx,
    output logic       found_above,
    output logic [2:0] first_idx,
    output logic       any
);

    // Scan downward so the last hit is the lowest qualifying bit
    always_comb begin
        next_idx    = 3'd0;
        found_above = 1'b0;
        first_idx   = 3'd0;
        any         = |mask;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                first_idx = 3'(i);
            end
            if (mask[i] && (3'(i) > idx)) begin
                next_idx    = 3'(i);
                found_above = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dec138_scan_seq.sv
// rtl/dec138_scan_seq.sv - walks a 74138-style decoder through the masked slots with dwell and blanking
module dec138_scan_seq #(
    parameter int DWELL_W   = 8,
    parameter int BLANK_CYC = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               e1_bar,
    output logic               e2_bar,
    output logic               e3,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    import dec138_scan_pkg::*;

    // Wide enough to hold BLANK_CYC-1 and never zero width
    localparam int BW = $clog2(BLANK_CYC + 2);
    localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    scan_state_t        state, state_n;
    logic [2:0]         idx, idx_n;
    logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_n;
    logic [DWELL_W-1:0] dwell_l, dwell_eff;
    logic [BW-1:0]      blank_cnt, blank_cnt_n;
    logic [7:0]         mask_l;
    logic               mode_l;
    logic               latch;
    logic               advance;
    logic               wrap_n;
    logic [2:0]         en, en_n;
    logic               busy_n;
    logic               done_n;

    logic [7:0]         search_mask;
    logic [2:0]         next_idx;
    logic               found_above;
    logic [2:0]         first_idx;
    logic               any;

    // A zero dwell still gives every slot one enabled cycle
    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

    // In IDLE the first slot comes from the incoming mask; afterwards only the latched copy matters
    assign search_mask = (state == IDLE) ? mask : mask_l;

    slot_next_find u_find (
        .mask        (search_mask),
        .idx         (idx),
        .next_idx    (next_idx),
        .found_above (found_above),
        .first_idx   (first_idx),
        .any         (any)
    );

    // State register plus every registered output
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 3'd0;
            dwell_cnt <= '0;
            blank_cnt <= '0;
            en        <= EN_OFF;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            dwell_cnt <= dwell_cnt_n;
            blank_cnt <= blank_cnt_n;
            en        <= en_n;
            busy      <= busy_n;
            done      <= done_n;
            wrap      <= wrap_n;
        end
    end

    // Scan configuration is frozen at the accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_l  <= 8'd0;
            mode_l  <= 1'b0;
            dwell_l <= '0;
        end else if (latch) begin
            mask_l  <= mask;
            mode_l  <= mode;
            dwell_l <= dwell_eff;
        end
    end

    // Next-state: stop beats start, dwell/blank counting, then slot advance
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        dwell_cnt_n = dwell_cnt;
        blank_cnt_n = blank_cnt;
        wrap_n      = 1'b0;
        latch       = 1'b0;
        advance     = 1'b0;

        if (stop) begin
            state_n     = IDLE;
            idx_n       = 3'd0;
            dwell_cnt_n = '0;
            blank_cnt_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        latch = 1'b1;
                        if (any) begin
                            state_n     = ACTIVE;
                            idx_n       = first_idx;
                            dwell_cnt_n = dwell_eff;
                        end else begin
                            state_n = DONE;
                            idx_n   = 3'd0;
                        end
                    end
                end
                ACTIVE: begin
                    if (dwell_cnt <= DWELL_W'(1)) begin
                        dwell_cnt_n = '0;
                        if (BLANK_CYC > 0) begin
                            state_n     = BLANK;
                            blank_cnt_n = '0;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        dwell_cnt_n = dwell_cnt - DWELL_W'(1);
                    end
                end
                BLANK: begin
                    if (blank_cnt == BLANK_LAST) begin
                        blank_cnt_n = '0;
                        advance     = 1'b1;
                    end else begin
                        blank_cnt_n = blank_cnt + BW'(1);
                    end
                end
                DONE: begin
                    state_n = IDLE;
                    idx_n   = 3'd0;
                end
                default: begin
                    state_n = IDLE;
                    idx_n   = 3'd0;
                end
            endcase

            if (advance) begin
                if (found_above) begin
                    state_n     = ACTIVE;
                    idx_n       = next_idx;
                    dwell_cnt_n = dwell_l;
                end else if (mode_l) begin
                    state_n     = ACTIVE;
                    idx_n       = first_idx;
                    dwell_cnt_n = dwell_l;
                    wrap_n      = 1'b1;
                end else begin
                    state_n = DONE;
                    idx_n   = 3'd0;
                end
            end
        end
    end

    // Output decode from the upcoming state so the registered outputs line up with it
    always_comb begin
        en_n   = (state_n == ACTIVE) ? EN_ON : EN_OFF;
        busy_n = state_is_busy(state_n);
        done_n = (state_n == DONE);
    end

    assign a      = idx[2];
    assign b      = idx[1];
    assign c      = idx[0];
    assign e1_bar = en[2];
    assign e2_bar = en[1];
    assign e3     = en[0];

endmodule

// File: tb/tb_dec138_scan_seq.sv
// tb/tb_dec138_scan_seq.sv - randomized and directed checks of the scan sequencer against a slot-list model
module tb_dec138_scan_seq;

    localparam int M_IDLE = 0;
    localparam int M_SCAN = 1;
    localparam int M_DONE = 2;
    localparam logic [8:0] OUT_IDLE = 9'b000_110_000;

    logic       clk = 1'b0;
    logic       rst, start, stop, mode;
    logic [7:0] mask;
    logic [7:0] dwell;

    // Index 0: BLANK_CYC=1 instance, index 1: BLANK_CYC=0 instance
    logic [1:0] o_a, o_b, o_c, o_e1, o_e2, o_e3, o_busy, o_done, o_wrap;

    int errors = 0;
    int checks = 0;

    int m_st   [2];
    int m_pos  [2];
    int m_k    [2];
    int m_pass [2];
    int m_n    [2];
    int m_d    [2];
    bit m_mode [2];
    int m_list [2][8];

    always #5 clk = ~clk;

    dec138_scan_seq #(.DWELL_W(8), .BLANK_CYC(1)) dut_b1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .mask(mask), .dwell(dwell),
        .a(o_a[0]), .b(o_b[0]), .c(o_c[0]),
        .e1_bar(o_e1[0]), .e2_bar(o_e2[0]), .e3(o_e3[0]),
        .busy(o_busy[0]), .done(o_done[0]), .wrap(o_wrap[0])
    );

    dec138_scan_seq #(.DWELL_W(8), .BLANK_CYC(0)) dut_b0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .mask(mask), .dwell(dwell),
        .a(o_a[1]), .b(o_b[1]), .c(o_c[1]),
        .e1_bar(o_e1[1]), .e2_bar(o_e2[1]), .e3(o_e3[1]),
        .busy(o_busy[1]), .done(o_done[1]), .wrap(o_wrap[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] obs(input int u);
        return {o_a[u], o_b[u], o_c[u], o_e1[u], o_e2[u], o_e3[u], o_busy[u], o_done[u], o_wrap[u]};
    endfunction

    function automatic int blank_of(input int u);
        return (u == 0) ? 1 : 0;
    endfunction

    // Expected outputs: position within the ordered slot list and within the slot period
    function automatic logic [8:0] model_out(input int u);
        logic [2:0] sel;
        logic       on;
        logic       wr;
        if (m_st[u] == M_IDLE) return OUT_IDLE;
        if (m_st[u] == M_DONE) return 9'b000_110_010;
        sel = 3'(m_list[u][m_pos[u]]);
        on  = (m_k[u] < m_d[u]);
        wr  = (m_pass[u] > 0) && (m_pos[u] == 0) && (m_k[u] == 0);
        return {sel, on ? 3'b001 : 3'b110, 1'b1, 1'b0, wr};
    endfunction

    task automatic model_step(input int u);
        if (rst || stop) begin
            m_st[u] = M_IDLE;
        end else begin
            case (m_st[u])
                M_IDLE: begin
                    if (start) begin
                        m_n[u] = 0;
                        for (int i = 0; i < 8; i++) begin
                            if (mask[i]) begin
                                m_list[u][m_n[u]] = i;
                                m_n[u]++;
                            end
                        end
                        m_mode[u] = mode;
                        m_d[u]    = (dwell == 0) ? 1 : int'(dwell);
                        if (m_n[u] == 0) begin
                            m_st[u] = M_DONE;
                        end else begin
                            m_st[u]   = M_SCAN;
                            m_pos[u]  = 0;
                            m_k[u]    = 0;
                            m_pass[u] = 0;
                        end
                    end
                end
                M_DONE: m_st[u] = M_IDLE;
                default: begin
                    m_k[u]++;
                    if (m_k[u] == m_d[u] + blank_of(u)) begin
                        m_k[u] = 0;
                        m_pos[u]++;
                        if (m_pos[u] == m_n[u]) begin
                            if (m_mode[u]) begin
                                m_pos[u] = 0;
                                m_pass[u]++;
                            end else begin
                                m_st[u] = M_DONE;
                            end
                        end
                    end
                end
            endcase
        end
    endtask

    // One clock: advance both models at the edge, compare just after it
    task automatic tick();
        @(posedge clk);
        for (int u = 0; u < 2; u++) model_step(u);
        #1;
        check("out_b1", 32'(obs(0)), 32'(model_out(0)));
        check("out_b0", 32'(obs(1)), 32'(model_out(1)));
    endtask

    initial begin
        int td0, td1, on0, on1, wr0, wr1, dn0, dn1;
        bit found;

        for (int u = 0; u < 2; u++) begin
            m_st[u] = M_IDLE; m_pos[u] = 0; m_k[u] = 0; m_pass[u] = 0;
            m_n[u] = 0; m_d[u] = 1; m_mode[u] = 1'b0;
        end
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; mask = 8'h00; dwell = 8'd0;
        tick();
        tick();
        check("rst_b1", 32'(obs(0)), 32'(OUT_IDLE));
        check("rst_b0", 32'(obs(1)), 32'(OUT_IDLE));
        rst = 1'b0;
        tick();

        // One-shot full mask, dwell 3
        mask = 8'hFF; dwell = 8'd3; mode = 1'b0; start = 1'b1;
        td0 = 0; td1 = 0; on0 = 0; on1 = 0;
        for (int t = 1; t <= 45; t++) begin
            tick();
            start = 1'b0;
            if (o_e3[0]) on0++;
            if (o_e3[1]) on1++;
            if (o_done[0] && td0 == 0) td0 = t;
            if (o_done[1] && td1 == 0) td1 = t;
        end
        check("done_lat_b1", td0, 33);
        check("done_lat_b0", td1, 25);
        check("en_cycles_b1", on0, 24);
        check("en_cycles_b0", on1, 24);

        // Continuous 2,5,7 with config scribbled mid-scan
        mask = 8'b1010_0100; dwell = 8'd2; mode = 1'b1; start = 1'b1;
        wr0 = 0; wr1 = 0; dn0 = 0; dn1 = 0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            start = 1'b0;
            if (t == 2) begin
                mask = 8'h00; mode = 1'b0; dwell = 8'd7;
            end
            if (o_wrap[0]) wr0++;
            if (o_wrap[1]) wr1++;
            if (o_done[0]) dn0++;
            if (o_done[1]) dn1++;
        end
        check("wraps_b1", wr0, 4);
        check("wraps_b0", wr1, 6);
        check("no_done_cont", dn0 + dn1, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();

        // Empty mask
        mask = 8'h00; dwell = 8'd2; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check("empty_done_b1", 32'(obs(0)), 32'(9'b000_110_010));
        check("empty_done_b0", 32'(obs(1)), 32'(9'b000_110_010));
        tick();
        check("empty_idle_b1", 32'(obs(0)), 32'(OUT_IDLE));

        // Stop with start in BLANK after slot 3
        mask = 8'hFF; dwell = 8'd2; mode = 1'b0; start = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            tick();
            start = 1'b0;
            if (m_st[0] == M_SCAN && m_list[0][m_pos[0]] == 3 && m_k[0] >= m_d[0]) found = 1'b1;
        end
        check("wait_blank3", 32'(found), 32'd1);
        check("in_blank3", 32'(obs(0)), 32'(9'b011_110_100));
        stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        check("stop_b1", 32'(obs(0)), 32'(OUT_IDLE));
        tick();
        check("stop_stay_b1", 32'(obs(0)), 32'(OUT_IDLE));

        // Zero dwell single slot, start while busy
        mask = 8'h01; dwell = 8'd0; mode = 1'b0; start = 1'b1;
        tick();
        check("dw0_on_b0", 32'(obs(1)), 32'(9'b000_001_100));
        tick();
        start = 1'b0;
        check("dw0_done_b0", 32'(obs(1)), 32'(9'b000_110_010));
        tick();
        check("dw0_idle_b0", 32'(obs(1)), 32'(OUT_IDLE));
        tick();

        // Reset during slot 5
        mask = 8'hFF; dwell = 8'd3; mode = 1'b0; start = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            tick();
            start = 1'b0;
            if (m_st[0] == M_SCAN && m_list[0][m_pos[0]] == 5 && m_k[0] < m_d[0]) found = 1'b1;
        end
        check("wait_slot5", 32'(found), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_b1", 32'(obs(0)), 32'(OUT_IDLE));
        tick();

        // Random traffic
        for (int t = 0; t < 600; t++) begin
            rst   = ($urandom_range(0, 199) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            start = ($urandom_range(0, 3) == 0);
            mode  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       mask = 8'h00;
                1:       mask = 8'(1 << $urandom_range(0, 7));
                default: mask = 8'($urandom);
            endcase
            dwell = 8'($urandom_range(0, 4));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
